// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: state encoding and the
// lamp pattern shown in each state.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_BA = 3'd0,
        A_GREEN    = 3'd1,
        A_YELLOW   = 3'd2,
        ALL_RED_AB = 3'd3,
        B_GREEN    = 3'd4,
        B_YELLOW   = 3'd5,
        PED_WALK   = 3'd6
    } state_t;

    typedef struct packed {
        logic a_red;
        logic a_yellow;
        logic a_green;
        logic b_red;
        logic b_yellow;
        logic b_green;
        logic walk;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED_BA = '{a_red: 1'b1, b_red: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_A_GREEN    = '{a_green: 1'b1, b_red: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_A_YELLOW   = '{a_yellow: 1'b1, b_red: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_ALL_RED_AB = '{a_red: 1'b1, b_red: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_B_GREEN    = '{a_red: 1'b1, b_green: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_B_YELLOW   = '{a_red: 1'b1, b_yellow: 1'b1, default: 1'b0};
    localparam lamps_t LAMPS_PED_WALK   = '{a_red: 1'b1, b_red: 1'b1, walk: 1'b1, default: 1'b0};

    // Undefined encodings show both roads red so the junction stays safe.
    function automatic lamps_t lamps_of(input state_t s);
        case (s)
            ALL_RED_BA: return LAMPS_ALL_RED_BA;
            A_GREEN:    return LAMPS_A_GREEN;
            A_YELLOW:   return LAMPS_A_YELLOW;
            ALL_RED_AB: return LAMPS_ALL_RED_AB;
            B_GREEN:    return LAMPS_B_GREEN;
            B_YELLOW:   return LAMPS_B_YELLOW;
            PED_WALK:   return LAMPS_PED_WALK;
            default:    return LAMPS_ALL_RED_BA;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for one phase: counts up from 0, flags the terminal count,
// and can optionally park at the terminal count instead of running on.
module phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear_i,
    input  logic          sat_en_i,
    input  logic [TW-1:0] terminal_i,
    output logic          done_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          at_terminal;

    assign at_terminal = (count_q == terminal_i);
    assign done_o      = at_terminal;

    // Next count: clear wins, otherwise advance unless parked at the terminal.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (!(sat_en_i && at_terminal)) begin
            count_d = count_q + TW'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// Two-road junction sequencer with a pedestrian crossing. Main road A rests
// on green and yields only to latched side-road or pedestrian demand; every
// direction change passes through an all-red clearance.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_A_T = 8,
    parameter int GREEN_B_T = 6,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 4,
    parameter int TW        = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sensor_b,
    input  logic       ped_req,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state_o
);

    state_t        state_q, state_d;
    logic          veh_b_pending_q, veh_b_pending_d;
    logic          ped_pending_q, ped_pending_d;
    logic          ret_b_q, ret_b_d;
    logic          ped_ack_q, ped_ack_d;

    logic [TW-1:0] terminal;
    logic          timer_done;
    logic          timer_clear;
    logic          entering_walk;
    logic          entering_b;
    lamps_t        lamps;

    // Terminal count for the current state is its dwell minus one.
    always_comb begin
        case (state_q)
            A_GREEN:  terminal = TW'(GREEN_A_T - 1);
            A_YELLOW: terminal = TW'(YELLOW_T - 1);
            B_GREEN:  terminal = TW'(GREEN_B_T - 1);
            B_YELLOW: terminal = TW'(YELLOW_T - 1);
            PED_WALK: terminal = TW'(WALK_T - 1);
            default:  terminal = TW'(ALLRED_T - 1);
        endcase
    end

    phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (timer_clear),
        .sat_en_i   (state_q == A_GREEN),
        .terminal_i (terminal),
        .done_o     (timer_done)
    );

    // Next-state, demand latches and the walk acknowledge.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d = state_q;
        ret_b_d = ret_b_q;

        case (state_q)
            ALL_RED_BA: begin
                if (timer_done) begin
                    if (ped_pending_q) begin
                        state_d = PED_WALK;
                        ret_b_d = 1'b0;
                    end else begin
                        state_d = A_GREEN;
                    end
                end
            end
            A_GREEN: begin
                if (timer_done && (veh_b_pending_q || ped_pending_q)) begin
                    state_d = A_YELLOW;
                end
            end
            A_YELLOW: begin
                if (timer_done) state_d = ALL_RED_AB;
            end
            ALL_RED_AB: begin
                // Pedestrian goes first; remember whether B still wants a turn.
                if (timer_done) begin
                    if (ped_pending_q) begin
                        state_d = PED_WALK;
                        ret_b_d = veh_b_pending_q;
                    end else begin
                        state_d = B_GREEN;
                    end
                end
            end
            PED_WALK: begin
                if (timer_done) state_d = ret_b_q ? B_GREEN : A_GREEN;
            end
            B_GREEN: begin
                if (timer_done) state_d = B_YELLOW;
            end
            B_YELLOW: begin
                if (timer_done) state_d = ALL_RED_BA;
            end
            default: begin
                state_d = ALL_RED_BA;
            end
        endcase

        timer_clear   = (state_d != state_q);
        entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
        entering_b    = (state_d == B_GREEN) && (state_q != B_GREEN);

        // Entry into the serving state clears a latch even if the request is
        // still high on that edge; a request during the walk is absorbed.
        veh_b_pending_d = entering_b ? 1'b0 : (veh_b_pending_q || sensor_b);
        ped_pending_d   = entering_walk ? 1'b0
                        : (ped_pending_q || (ped_req && (state_q != PED_WALK)));
        ped_ack_d       = entering_walk;
    end

    // State and demand registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of the others.
        if (!rstn) begin
            state_q         <= ALL_RED_BA;
            veh_b_pending_q <= 1'b0;
            ped_pending_q   <= 1'b0;
            ret_b_q         <= 1'b0;
            ped_ack_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            veh_b_pending_q <= veh_b_pending_d;
            ped_pending_q   <= ped_pending_d;
            ret_b_q         <= ret_b_d;
            ped_ack_q       <= ped_ack_d;
        end
    end

    // Lamps decode from the state register only.
    assign lamps    = lamps_of(state_q);
    assign a_red    = lamps.a_red;
    assign a_yellow = lamps.a_yellow;
    assign a_green  = lamps.a_green;
    assign b_red    = lamps.b_red;
    assign b_yellow = lamps.b_yellow;
    assign b_green  = lamps.b_green;
    assign walk     = lamps.walk;
    assign ped_ack  = ped_ack_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: phase sequencing, pedestrian
// priority, mid-run reset, plus a per-cycle safety monitor under random demand.
module tb_intersection_controller;

    localparam int S_AR_BA  = 0;
    localparam int S_A_GRN  = 1;
    localparam int S_A_YEL  = 2;
    localparam int S_AR_AB  = 3;
    localparam int S_B_GRN  = 4;
    localparam int S_B_YEL  = 5;
    localparam int S_WALK   = 6;

    logic       clk;
    logic       rstn;
    logic       sensor_b;
    logic       ped_req;
    logic       a_red, a_yellow, a_green;
    logic       b_red, b_yellow, b_green;
    logic       walk;
    logic       ped_ack;
    logic [2:0] state_o;

    int n_checks;
    int n_pass;
    int n_fail;
    int inv_fail;

    intersection_controller dut (
        .clk      (clk),
        .rstn     (rstn),
        .sensor_b (sensor_b),
        .ped_req  (ped_req),
        .a_red    (a_red),
        .a_yellow (a_yellow),
        .a_green  (a_green),
        .b_red    (b_red),
        .b_yellow (b_yellow),
        .b_green  (b_green),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written lamp pattern {a_r,a_y,a_g,b_r,b_y,b_g,walk} per state.
    function automatic logic [6:0] exp_lamps(input int st);
        case (st)
            S_A_GRN: return 7'b0011000;
            S_A_YEL: return 7'b0101000;
            S_B_GRN: return 7'b1000010;
            S_B_YEL: return 7'b1000100;
            S_WALK:  return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect n consecutive cycles in state st; ped_ack only on the first
    // cycle when ack_first is set.
    task automatic expect_phase(input string tag, input int st, input int n, input bit ack_first);
        for (int i = 0; i < n; i++) begin
            check({tag, " state"}, 32'(state_o), 32'(st));
            check({tag, " lamps"},
                  32'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk}),
                  32'(exp_lamps(st)));
            check({tag, " ack"}, 32'(ped_ack), 32'(ack_first && (i == 0)));
            tick();
        end
    endtask

    // Safety monitor sampled away from the active edge, every cycle.
    always @(negedge clk) begin
        assert (($countones({a_red, a_yellow, a_green}) == 1) &&
                ($countones({b_red, b_yellow, b_green}) == 1) &&
                (a_red || b_red) &&
                (!walk || (a_red && b_red)) &&
                (!ped_ack || walk))
        else begin
            inv_fail++;
            $error("FAIL safety: lamps %b%b%b %b%b%b walk %b ack %b",
                   a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, ped_ack);
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        inv_fail = 0;
        rstn     = 1'b0;
        sensor_b = 1'b0;
        ped_req  = 1'b0;
        tick();
        tick();

        // Reset state, then release: A green from the second edge, then rest.
        expect_phase("reset", S_AR_BA, 1, 1'b0);
        rstn = 1'b1;
        expect_phase("release", S_AR_BA, 2, 1'b0);
        expect_phase("a_rest", S_A_GRN, 100, 1'b0);

        // Side road held: one catch-up cycle, then two full 22-cycle periods.
        sensor_b = 1'b1;
        expect_phase("veh latch", S_A_GRN, 2, 1'b0);
        expect_phase("p1 a_yel", S_A_YEL, 2, 1'b0);
        expect_phase("p1 ar_ab", S_AR_AB, 2, 1'b0);
        expect_phase("p1 b_grn", S_B_GRN, 6, 1'b0);
        expect_phase("p1 b_yel", S_B_YEL, 2, 1'b0);
        expect_phase("p1 ar_ba", S_AR_BA, 2, 1'b0);
        expect_phase("p2 a_grn", S_A_GRN, 8, 1'b0);
        expect_phase("p2 a_yel", S_A_YEL, 2, 1'b0);
        expect_phase("p2 ar_ab", S_AR_AB, 2, 1'b0);
        sensor_b = 1'b0;
        expect_phase("p2 b_grn", S_B_GRN, 6, 1'b0);
        expect_phase("p2 b_yel", S_B_YEL, 2, 1'b0);
        expect_phase("p2 ar_ba", S_AR_BA, 2, 1'b0);

        // Pedestrian pulse at A_GREEN timer=3: full green, then walk, back to A.
        expect_phase("ped t0-2", S_A_GRN, 3, 1'b0);
        ped_req = 1'b1;
        expect_phase("ped t3", S_A_GRN, 1, 1'b0);
        ped_req = 1'b0;
        expect_phase("ped t4-7", S_A_GRN, 4, 1'b0);
        expect_phase("ped a_yel", S_A_YEL, 2, 1'b0);
        expect_phase("ped ar_ab", S_AR_AB, 2, 1'b0);
        expect_phase("ped walk", S_WALK, 4, 1'b1);
        expect_phase("ped back_a", S_A_GRN, 10, 1'b0);

        // Both demands at once: walk first, then B; a mid-walk press is absorbed.
        sensor_b = 1'b1;
        ped_req  = 1'b1;
        expect_phase("both latch", S_A_GRN, 1, 1'b0);
        sensor_b = 1'b0;
        ped_req  = 1'b0;
        expect_phase("both a_grn", S_A_GRN, 1, 1'b0);
        expect_phase("both a_yel", S_A_YEL, 2, 1'b0);
        expect_phase("both ar_ab", S_AR_AB, 2, 1'b0);
        expect_phase("both walk0", S_WALK, 2, 1'b1);
        ped_req = 1'b1;
        expect_phase("both walk2", S_WALK, 1, 1'b0);
        ped_req = 1'b0;
        expect_phase("both walk3", S_WALK, 1, 1'b0);
        expect_phase("both b_grn", S_B_GRN, 6, 1'b0);
        expect_phase("both b_yel", S_B_YEL, 2, 1'b0);
        expect_phase("both ar_ba", S_AR_BA, 2, 1'b0);
        expect_phase("no rewalk", S_A_GRN, 10, 1'b0);

        // Reset during B_GREEN timer=3 with fresh demands latched.
        sensor_b = 1'b1;
        expect_phase("rst latch", S_A_GRN, 1, 1'b0);
        sensor_b = 1'b0;
        expect_phase("rst a_grn", S_A_GRN, 1, 1'b0);
        expect_phase("rst a_yel", S_A_YEL, 2, 1'b0);
        expect_phase("rst ar_ab", S_AR_AB, 2, 1'b0);
        expect_phase("rst b_t0", S_B_GRN, 1, 1'b0);
        sensor_b = 1'b1;
        ped_req  = 1'b1;
        expect_phase("rst b_t1", S_B_GRN, 1, 1'b0);
        sensor_b = 1'b0;
        ped_req  = 1'b0;
        expect_phase("rst b_t2", S_B_GRN, 1, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        expect_phase("rst mid", S_AR_BA, 2, 1'b0);
        expect_phase("rst restart", S_A_GRN, 12, 1'b0);

        // Random demand; the safety monitor watches every cycle.
        for (int i = 0; i < 10000; i++) begin
            sensor_b = ($urandom_range(0, 7) == 0);
            ped_req  = ($urandom_range(0, 15) == 0);
            tick();
        end
        sensor_b = 1'b0;
        ped_req  = 1'b0;
        tick();
        check("safety violations", 32'(inv_fail), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
